decode_imm_stage: RTL and testbench
===================================

# decode_imm_stage

Registered decode/immediate-generation stage sitting between the fetch stage and the register-file read in the pipelined core. It accepts one 32-bit RISC-V instruction per handshake, extracts register/opcode/funct fields, and forms the XLEN-wide immediate. It flags illegal encodings and presents the result through a one-cycle output register with valid/ready flow control and synchronous flush. It generalises the single-cycle immediate splitter to XLEN 32/64, adds full RV shift-amount rules, illegal detection and pipelined handshaking.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous kill of all held and incoming instructions
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept this cycle
- in_inst  input  32  instruction word
- in_pc  input  XLEN  instruction address
- out_valid  output  1  decoded instruction valid
- out_ready  input  1  downstream accepts this cycle
- out_pc  output  XLEN  registered in_pc
- out_inst  output  32  registered in_inst
- out_op  output  7  inst[6:0]
- out_rd, out_rs1, out_rs2  output  5 each  inst[11:7], inst[19:15], inst[24:20]
- out_funct3  output  3  inst[14:12]
- out_funct7  output  7  inst[31:25]
- out_imm  output  XLEN  immediate, per Operation
- out_imm_fmt  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT
- out_illegal  output  1  unsupported encoding

## Operation
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BR 1100011, LD 0000011, ST 0100011, OP_IMM 0010011, OP 0110011, FENCE 0001111, SYSTEM 1110011.
- Immediates, all sign-extended from the top encoded bit to XLEN:
  - LUI/AUIPC: {inst[31:12], 12'b0}, fmt U (XLEN=64: bit 31 replicated to 63:32).
  - JAL: {inst[31], inst[19:12], inst[20], inst[30:21], 0}, fmt J.
  - JALR, LD: inst[31:20], fmt I.
  - BR: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, fmt B.
  - ST: {inst[31:25], inst[11:7]}, fmt S.
  - OP_IMM funct3 000/010/011/100/110/111 (incl. SLTIU): inst[31:20] sign-extended, fmt I.
  - OP_IMM funct3 001/101: zero-extended shamt, fmt SHAMT; XLEN=32 uses inst[24:20], XLEN=64 uses inst[25:20].
  - OP, FENCE, SYSTEM: imm 0, fmt NONE.
- out_illegal = 1 when inst[1:0] != 2'b11, op not in the list, or XLEN=32 shift with inst[25]=1. Illegal instructions still flow with valid; imm 0, fmt NONE.
- Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
- Output register loads decoded data on input transfer; holds all outputs stable while out_valid && !out_ready.
- flush: next cycle out_valid=0 and any buffered entry dropped; an input transferred in the flush cycle is discarded.

## Timing
- Reset: out_valid=0, in_ready=1, all data outputs 0, out_imm_fmt=0, out_illegal=0.
- Latency: 1 cycle, in transfer at edge N -> out_valid at N+1.
- Throughput: one instruction per cycle when out_ready held high.
- Simultaneous out transfer and in transfer: register replaced, out_valid stays 1, no bubble.
- flush has priority over any transfer in the same cycle.
- rst asserted mid-stream: all state cleared immediately, regardless of clk.

## Configuration
- DECODE_IMM_SKID_EN defined: a one-entry skid buffer is added; in_ready is a register output (= !skid_valid), no combinational path from out_ready. Under stall, one extra instruction is absorbed in the skid; in_ready drops the following cycle; the skid drains into the output register first when out_ready returns (order preserved).
- Undefined: no skid; in_ready = !out_valid || out_ready (combinational).

## Test plan
- 0xFFF00093 (addi x1,x0,-1) -> next cycle out_imm=0xFFFFFFFF, fmt I, rd=1, illegal=0.
- 0x123452B7 (lui x5,0x12345) -> out_imm=0x12345000, fmt U; XLEN=64 with 0x800002B7 -> 0xFFFFFFFF80000000.
- 0xFFDFF06F (jal x0,-4) -> 0xFFFFFFFC fmt J; 0x00000463 (beq +8) -> 0x00000008 fmt B; 0x00309093 (slli x1,x1,3) -> 3 fmt SHAMT.
- 0x0000000B (unknown op) and 0x00000001 -> out_illegal=1, imm 0.
- Stream 4 instructions, out_ready low 3 cycles mid-stream -> no loss/duplication, order kept; with skid, in_ready falls exactly one cycle after stall starts.
- flush pulsed while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, both instructions absent from output.

Source files
------------

// File: rtl/decode_imm_stage.sv
// Registered RV32/RV64 decode and immediate stage with valid/ready handshake.
// Define DECODE_IMM_SKID_EN for a one-entry skid buffer (registered in_ready).
module decode_imm_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [6:0]      out_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_fmt,
  output logic            out_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_ST     = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F_NONE  = 3'd0;
  localparam logic [2:0] F_I     = 3'd1;
  localparam logic [2:0] F_S     = 3'd2;
  localparam logic [2:0] F_B     = 3'd3;
  localparam logic [2:0] F_U     = 3'd4;
  localparam logic [2:0] F_J     = 3'd5;
  localparam logic [2:0] F_SHAMT = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } dec_t;

  dec_t       d;
  dec_t       q;
  logic       ov;
  logic [6:0] op;
  logic [2:0] f3;
  logic       in_fire;

  assign op = in_inst[6:0];
  assign f3 = in_inst[14:12];

  always_comb begin
    d      = '0;
    d.pc   = in_pc;
    d.inst = in_inst;
    unique case (op)
      OP_LUI, OP_AUIPC: begin
        d.imm = XLEN'($signed({in_inst[31:12], 12'b0}));
        d.fmt = F_U;
      end
      OP_JAL: begin
        d.imm = XLEN'($signed({in_inst[31], in_inst[19:12],
                               in_inst[20], in_inst[30:21], 1'b0}));
        d.fmt = F_J;
      end
      OP_JALR, OP_LD: begin
        d.imm = XLEN'($signed(in_inst[31:20]));
        d.fmt = F_I;
      end
      OP_BR: begin
        d.imm = XLEN'($signed({in_inst[31], in_inst[7],
                               in_inst[30:25], in_inst[11:8], 1'b0}));
        d.fmt = F_B;
      end
      OP_ST: begin
        d.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
        d.fmt = F_S;
      end
      OP_IMM: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          if (XLEN == 32) begin
            // RV32 shifts only have a 5-bit shamt; bit 25 set is reserved
            if (in_inst[25]) begin
              d.ill = 1'b1;
            end else begin
              d.imm = XLEN'(in_inst[24:20]);
              d.fmt = F_SHAMT;
            end
          end else begin
            d.imm = XLEN'(in_inst[25:20]);
            d.fmt = F_SHAMT;
          end
        end else begin
          d.imm = XLEN'($signed(in_inst[31:20]));
          d.fmt = F_I;
        end
      end
      OP_OP, OP_FENCE, OP_SYSTEM: begin
        d.fmt = F_NONE;
      end
      default: begin
        d.ill = 1'b1;
      end
    endcase
  end

`ifdef DECODE_IMM_SKID_EN
  dec_t s;
  logic s_v;
  logic stall;

  assign in_ready = !s_v;
  assign in_fire  = in_valid && in_ready;
  assign stall    = ov && !out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      ov  <= 1'b0;
      s   <= '0;
      s_v <= 1'b0;
    end else if (flush) begin
      ov  <= 1'b0;
      s_v <= 1'b0;
    end else if (stall) begin
      if (in_fire) begin
        s   <= d;
        s_v <= 1'b1;
      end
    end else if (s_v) begin
      // skid holds the older entry, so it drains before new input
      q   <= s;
      ov  <= 1'b1;
      s_v <= 1'b0;
    end else if (in_fire) begin
      q  <= d;
      ov <= 1'b1;
    end else begin
      ov <= 1'b0;
    end
  end
`else
  assign in_ready = !ov || out_ready;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= '0;
      ov <= 1'b0;
    end else if (flush) begin
      ov <= 1'b0;
    end else if (in_fire) begin
      q  <= d;
      ov <= 1'b1;
    end else if (out_ready) begin
      ov <= 1'b0;
    end
  end
`endif

  assign out_valid   = ov;
  assign out_pc      = q.pc;
  assign out_inst    = q.inst;
  assign out_op      = q.inst[6:0];
  assign out_rd      = q.inst[11:7];
  assign out_rs1     = q.inst[19:15];
  assign out_rs2     = q.inst[24:20];
  assign out_funct3  = q.inst[14:12];
  assign out_funct7  = q.inst[31:25];
  assign out_imm     = q.imm;
  assign out_imm_fmt = q.fmt;
  assign out_illegal = q.ill;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Self-checking bench for decode_imm_stage: directed cases, stall,
// flush, async reset and a randomized stream against a queue model.
module tb_decode_imm_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_inst = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic [6:0]      out_op;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_imm_fmt;
  logic            out_illegal;

  decode_imm_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_op(out_op),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_imm_fmt(out_imm_fmt),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } ent_t;

  ent_t            mq[$];
  int              ncmp = 0;
  int              nfail = 0;
  int              npop = 0;
  logic [XLEN-1:0] pcv = '0;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int n);
    longint m;
    m = longint'(1) << n;
    v = v & (m - 1);
    if (v >= (m >> 1)) v = v - m;
    return v;
  endfunction

  function automatic logic [XLEN-1:0] tr(input logic [63:0] v);
    return v[XLEN-1:0];
  endfunction

  task automatic ref_dec(input logic [31:0] i, output logic [XLEN-1:0] imm,
                         output logic [2:0] fmt, output logic ill);
    longint r;
    longint u;
    u = longint'(i);
    r = 0;
    fmt = 3'd0;
    ill = 1'b0;
    case (i[6:0])
      7'h37, 7'h17: begin
        r = sx(u & 64'hFFFFF000, 32); fmt = 3'd4;
      end
      7'h6F: begin
        r = ((u >> 31) & 1) * (1 << 20) + ((u >> 12) & 255) * (1 << 12)
          + ((u >> 20) & 1) * (1 << 11) + ((u >> 21) & 1023) * 2;
        r = sx(r, 21); fmt = 3'd5;
      end
      7'h67, 7'h03: begin
        r = sx(u >> 20, 12); fmt = 3'd1;
      end
      7'h63: begin
        r = ((u >> 31) & 1) * (1 << 12) + ((u >> 7) & 1) * (1 << 11)
          + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2;
        r = sx(r, 13); fmt = 3'd3;
      end
      7'h23: begin
        r = sx(((u >> 25) & 127) * 32 + ((u >> 7) & 31), 12); fmt = 3'd2;
      end
      7'h13: begin
        if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
          if (XLEN == 32 && i[25]) ill = 1'b1;
          else begin
            r = (u >> 20) & ((XLEN == 32) ? 31 : 63); fmt = 3'd6;
          end
        end else begin
          r = sx(u >> 20, 12); fmt = 3'd1;
        end
      end
      7'h33, 7'h0F, 7'h73: fmt = 3'd0;
      default: ill = 1'b1;
    endcase
    imm = tr(r);
  endtask

  task automatic cyc(input logic vi, input logic [31:0] ins,
                     input logic [XLEN-1:0] pc, input logic ordy,
                     input logic fl, output logic acc);
    logic [XLEN-1:0] ei;
    logic [2:0]      ef;
    logic            el;
    ent_t            e;
    logic            ov;
    logic            ir;
    in_valid = vi;
    in_inst = ins;
    in_pc = pc;
    out_ready = ordy;
    flush = fl;
    @(negedge clk);
    ov = out_valid;
    ir = in_ready;
    chk("out_valid", ov, mq.size() != 0);
`ifdef DECODE_IMM_SKID_EN
    chk("in_ready", ir, mq.size() < 2);
`else
    chk("in_ready", ir, mq.size() == 0 || ordy);
`endif
    if (mq.size() != 0) begin
      e = mq[0];
      ref_dec(e.inst, ei, ef, el);
      chk("decode",
          {out_pc, out_inst, out_op, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_imm_fmt, out_illegal},
          {e.pc, e.inst, e.inst[6:0], e.inst[11:7], e.inst[19:15],
           e.inst[24:20], e.inst[14:12], e.inst[31:25], ei, ef, el});
    end
    acc = vi && ir && !fl;
    if (fl) mq.delete();
    else begin
      if (ov && ordy && mq.size() != 0) begin
        void'(mq.pop_front());
        npop++;
      end
      if (acc) begin
        e.pc = pc;
        e.inst = ins;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic dir(input string tag, input logic [31:0] ins,
                     input logic [XLEN-1:0] eimm, input logic [2:0] efmt,
                     input logic eill);
    logic a;
    cyc(1'b1, ins, pcv, 1'b1, 1'b0, a);
    pcv = pcv + 4;
    chk(tag, {out_valid, out_imm, out_imm_fmt, out_illegal},
        {1'b1, eimm, efmt, eill});
  endtask

  logic [6:0]  ops[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                           7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
  logic [31:0] sinst[4] = '{32'h00100093, 32'h00200113,
                            32'h00300193, 32'h00400213};

  initial begin
    logic        a;
    logic [31:0] r;
    int          idx;
    int          p0;
    int          k;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", {out_valid, in_ready, out_pc, out_inst, out_imm,
                  out_imm_fmt, out_illegal},
        {1'b0, 1'b1, {XLEN{1'b0}}, 32'h0, {XLEN{1'b0}}, 3'd0, 1'b0});
    rst = 1'b0;
    @(posedge clk);
    #1;

    dir("addi", 32'hFFF00093, tr(64'hFFFFFFFFFFFFFFFF), 3'd1, 1'b0);
    chk("addi_rd", out_rd, 5'd1);
    dir("lui", 32'h123452B7, tr(64'h12345000), 3'd4, 1'b0);
    dir("lui_neg", 32'h800002B7, tr(64'hFFFFFFFF80000000), 3'd4, 1'b0);
    dir("jal", 32'hFFDFF06F, tr(64'hFFFFFFFFFFFFFFFC), 3'd5, 1'b0);
    dir("beq", 32'h00000463, tr(64'h8), 3'd3, 1'b0);
    dir("slli", 32'h00309093, tr(64'h3), 3'd6, 1'b0);
    dir("sw", 32'hFE112E23, tr(64'hFFFFFFFFFFFFFFFC), 3'd2, 1'b0);
    if (XLEN == 32) dir("slli25", 32'h02009093, '0, 3'd0, 1'b1);
    else dir("slli25", 32'h02009093, tr(64'h20), 3'd6, 1'b0);
    dir("unk_op", 32'h0000000B, '0, 3'd0, 1'b1);
    dir("bad_len", 32'h00000001, '0, 3'd0, 1'b1);
    dir("add", 32'h002081B3, '0, 3'd0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, a);

    // stream of 4 with a 3-cycle downstream stall
    idx = 0;
    p0 = npop;
    for (int c = 0; c < 40 && (idx < 4 || mq.size() != 0); c++) begin
      cyc(idx < 4, (idx < 4) ? sinst[idx] : 32'h0, pcv,
          !(c >= 2 && c < 5), 1'b0, a);
      if (a) begin
        idx++;
        pcv = pcv + 4;
      end
    end
    chk("stream_cnt", npop - p0, 4);

    cyc(1'b1, 32'h00500293, pcv, 1'b0, 1'b0, a);
    cyc(1'b1, 32'h00600313, pcv + 4, 1'b1, 1'b1, a);
    chk("flush_ov", out_valid, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, a);

    for (int c = 0; c < 400; c++) begin
      r = $urandom();
      k = $urandom_range(0, 15);
      if (k < 11) r = {r[31:7], ops[k]};
      cyc($urandom_range(0, 9) < 7, r, tr({$urandom(), $urandom()}),
          $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, a);
    end
    for (int c = 0; c < 4; c++) cyc(1'b0, '0, '0, 1'b1, 1'b0, a);

    cyc(1'b1, 32'h00700393, pcv, 1'b0, 1'b0, a);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {out_valid, in_ready, out_inst}, {1'b0, 1'b1, 32'h0});
    mq.delete();
    in_valid = 1'b0;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, '0, '0, 1'b1, 1'b0, a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
